dm_access_sched: RTL and testbench

//  Controls the data memory from the MEM stage. The data memory has a fixed access latency and stays word-organised.

---
 rtl/dm_pkg.sv | 55 +++++
 rtl/dm_lane_align.sv | 64 ++++++
 rtl/dm_access_sched.sv | 183 ++++++++++++++++++
 tb/tb_dm_access_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access scheduler.
//   - store size and load kind encodings carried on cpu_op_s / cpu_op_l
//   - scheduler FSM state encoding
//   - access owner encoding (CPU MEM stage or external requester)
//   - misaligned(): alignment rule for a CPU access
package dm_pkg;

  typedef enum logic [2:0] {
    OP_SW = 3'd0,
    OP_SB = 3'd1,
    OP_SH = 3'd2
  } op_s_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LBU = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LH  = 3'd4
  } op_l_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_EXT = 1'b1
  } owner_e;

  // Words need addr[1:0]==0, halves need addr[0]==0, bytes are always aligned.
  // Unknown size codes are treated as words.
  function automatic logic misaligned(input logic we, input logic [2:0] op_s,
                                      input logic [2:0] op_l, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if (we) begin
      case (op_s)
        OP_SB:   bad = 1'b0;
        OP_SH:   bad = lane[0];
        default: bad = (lane != 2'b00);
      endcase
    end else begin
      case (op_l)
        OP_LBU, OP_LB: bad = 1'b0;
        OP_LHU, OP_LH: bad = lane[0];
        default:       bad = (lane != 2'b00);
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering between the CPU and the word-organised memory.
//   Store side: op_s, st_lane (addr[1:0]), st_data -> be, wdata (lane-replicated)
//   Load side:  op_l, ld_lane (addr[1:0]), raw word -> ld_data (lane moved to bit 0)
// Configuration macro DM_LOAD_EXT_EN:
//   defined   - lb/lh sign-extend, lbu/lhu zero-extend (final register value)
//   undefined - every sub-word load is zero-extended; lb/lh act as lbu/lhu
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  op_s,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  op_l,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] raw,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = 4'hF;
    wdata = st_data;
    case (op_s)
      OP_SB: begin
        be    = 4'b0001 << st_lane;
        wdata = {4{st_data[7:0]}};
      end
      OP_SH: begin
        // Half lanes sit at byte offset 0 or 2.
        be    = 4'b0011 << {st_lane[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lane)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = ld_lane[1] ? raw[31:16] : raw[15:0];

    case (op_l)
      OP_LBU:  ld_data = {24'h0, byte_sel};
      OP_LHU:  ld_data = {16'h0, half_sel};
`ifdef DM_LOAD_EXT_EN
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
`else
      OP_LB:   ld_data = {24'h0, byte_sel};
      OP_LH:   ld_data = {16'h0, half_sel};
`endif
      default: ld_data = raw;
    endcase
  end

endmodule

// File: rtl/dm_access_sched.sv
// Data-memory access scheduler for the MEM stage.
// Arbitrates a fixed-latency, word-organised data memory between the CPU MEM
// stage and an external requester, sequences each access (IDLE/WAIT/RESP),
// stalls the pipeline during CPU accesses and aligns sub-word loads.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cpu_req/we/op_s/op_l/addr/wdata -> CPU request; cpu_rdata, cpu_stall, cpu_addr_err back
//   ext_req/we/addr/wdata        -> external request; ext_rdata, ext_done back
//   mem_en/we/be/addr/wdata      -> memory strobe (registered); mem_rdata raw word in
// Parameters: LATENCY (mem_en to mem_rdata, >=1), STARVE_LIMIT (CPU grants
// allowed while ext_req waits).
// Configuration macro DM_LOAD_EXT_EN selects in-block load sign extension
// (handled inside dm_lane_align).
module dm_access_sched
  import dm_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_op_s,
  input  logic [2:0]  cpu_op_l,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_addr_err,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e          state, state_next;
  owner_e          owner;
  logic [CW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic [2:0]      op_l_q;
  logic [1:0]      lane_q;
  logic            we_q;
  logic [31:0]     data_q;

  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;

  logic idle, resp, starved, cpu_wins, cpu_misal, grant_cpu, grant_ext;

  assign idle      = (state == ST_IDLE);
  assign resp      = (state == ST_RESP);
  assign starved   = ext_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign cpu_wins  = cpu_req && !starved;
  assign cpu_misal = misaligned(cpu_we, cpu_op_s, cpu_op_l, cpu_addr[1:0]);
  // A misaligned CPU request still wins the cycle; it is dropped with an error.
  assign grant_cpu = idle && cpu_wins && !cpu_misal;
  assign grant_ext = idle && ext_req && !cpu_wins;

  dm_lane_align u_align (
    .op_s    (cpu_op_s),
    .st_lane (cpu_addr[1:0]),
    .st_data (cpu_wdata),
    .be      (st_be),
    .wdata   (st_wdata),
    .op_l    (op_l_q),
    .ld_lane (lane_q),
    .raw     (mem_rdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_cpu || grant_ext) state_next = ST_WAIT;
      ST_WAIT: if (lat_cnt == '0) state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so the pipeline sees no stall.
  always_comb begin
    cpu_stall    = 1'b0;
    cpu_addr_err = 1'b0;
    cpu_rdata    = 32'h0;
    ext_rdata    = 32'h0;
    ext_done     = 1'b0;
    if (!reset) begin
      cpu_addr_err = idle && cpu_wins && cpu_misal;
      cpu_stall    = cpu_req && !(resp && owner == OWNER_CPU) && !cpu_addr_err;
      if (resp && owner == OWNER_CPU) cpu_rdata = data_q;
      if (resp && owner == OWNER_EXT) begin
        ext_done  = 1'b1;
        ext_rdata = data_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWNER_CPU;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      op_l_q     <= 3'd0;
      lane_q     <= 2'd0;
      we_q       <= 1'b0;
      data_q     <= 32'h0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      // Memory strobe is a single-cycle pulse in the first WAIT cycle.
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;

      if (grant_cpu) begin
        owner     <= OWNER_CPU;
        lat_cnt   <= CW'(LATENCY);
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_be    <= cpu_we ? st_be : 4'hF;
        mem_addr  <= cpu_addr & WORD_MASK;
        mem_wdata <= cpu_we ? st_wdata : 32'h0;
        op_l_q    <= cpu_op_l;
        lane_q    <= cpu_addr[1:0];
        we_q      <= cpu_we;
      end else if (grant_ext) begin
        owner     <= OWNER_EXT;
        lat_cnt   <= CW'(LATENCY);
        mem_en    <= 1'b1;
        mem_we    <= ext_we;
        mem_be    <= 4'hF;
        mem_addr  <= ext_addr & WORD_MASK;
        mem_wdata <= ext_we ? ext_wdata : 32'h0;
        we_q      <= ext_we;
      end

      // The memory word is valid on the edge where the counter has reached 0.
      if (state == ST_WAIT) begin
        if (lat_cnt == '0) begin
          if (we_q)                    data_q <= 32'h0;
          else if (owner == OWNER_CPU) data_q <= ld_data;
          else                         data_q <= mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end

      if (!ext_req || grant_ext) starve_cnt <= '0;
      else if (grant_cpu)        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A granted requester must hold its request until the response cycle.
  a_cpu_hold: assert property (@(posedge clk) disable iff (reset)
    (state != ST_IDLE && owner == OWNER_CPU) |-> cpu_req);
  a_ext_hold: assert property (@(posedge clk) disable iff (reset)
    (state != ST_IDLE && owner == OWNER_EXT) |-> ext_req);

endmodule

// File: tb/tb_dm_access_sched.sv
module tb_dm_access_sched;
  import dm_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_op_s, cpu_op_l;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_addr_err;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_done;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dm_access_sched #(.LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op_s(cpu_op_s), .cpu_op_l(cpu_op_l),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_addr_err(cpu_addr_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: 16 words, byte-enabled writes, read data LAT cycles after mem_en.
  logic [31:0] mem  [16];
  logic [31:0] pipe [LAT];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h8899AABB;
      mem[9] <= 32'h0BADF00D;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem[mem_addr[5:2]] : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Results of the most recent CPU access.
  int          r_stalls, r_ens;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_err;

  // Called at posedge+1 with the scheduler idle; returns at posedge+1 after the response.
  task automatic cpu_access(input logic we, input logic [2:0] op_s, input logic [2:0] op_l,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic done;
    cpu_req = 1'b1; cpu_we = we; cpu_op_s = op_s; cpu_op_l = op_l;
    cpu_addr = addr; cpu_wdata = wdata;
    r_stalls = 0; r_ens = 0; r_be = 4'h0; r_addr = 32'h0; r_wdata = 32'h0;
    r_we = 1'b0; r_err = 1'b0; r_rdata = 32'h0; done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (mem_en) begin
        r_ens++; r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
      end
      if (cpu_addr_err) r_err = 1'b1;
      if (cpu_stall) r_stalls++;
      else begin
        done = 1'b1;
        r_rdata = cpu_rdata;
      end
    end
    check_val("cpu_done", {31'h0, done}, 32'h1);
    $display("cpu we=%0b addr=%08h stalls=%0d en=%0d be=%h wdata=%08h rdata=%08h err=%0b",
             we, addr, r_stalls, r_ens, r_be, r_wdata, r_rdata, r_err);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] first_addr, ext_data, exp_lb, exp_lh;
    logic        ext_drop, cdone;
    int          ext_at, cpu_at;

`ifdef DM_LOAD_EXT_EN
    exp_lb = 32'hFFFFFF99;
    exp_lh = 32'hFFFF8899;
`else
    exp_lb = 32'h00000099;
    exp_lh = 32'h00008899;
`endif

    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_op_s = 3'd0; cpu_op_l = 3'd0;
    cpu_addr = 32'h20; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;

    // Reset state, with a request present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check_val("rst_ctrl", {24'h0, mem_en, mem_we, mem_be, cpu_addr_err, ext_done}, 32'h0);
    check_val("rst_addr", mem_addr, 32'h0);
    check_val("rst_rdata", cpu_rdata | ext_rdata | mem_wdata, 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // sw: one strobe, full enables, 4 stall cycles.
    cpu_access(1'b1, OP_SW, OP_LW, 32'h10, 32'hDEADBEEF);
    check_val("sw_stalls", r_stalls, 32'd4);
    check_val("sw_en_cnt", r_ens, 32'd1);
    check_val("sw_be", {28'h0, r_be}, 32'hF);
    check_val("sw_addr", r_addr, 32'h10);
    check_val("sw_wdata", r_wdata, 32'hDEADBEEF);
    check_val("sw_we", {31'h0, r_we}, 32'h1);

    // Sub-word stores.
    cpu_access(1'b1, OP_SB, OP_LW, 32'h13, 32'h0000005A);
    check_val("sb_be", {28'h0, r_be}, 32'h8);
    check_val("sb_wdata", r_wdata, 32'h5A5A5A5A);
    check_val("sb_addr", r_addr, 32'h10);
    cpu_access(1'b1, OP_SH, OP_LW, 32'h12, 32'h00001234);
    check_val("sh_be", {28'h0, r_be}, 32'hC);
    check_val("sh_wdata", r_wdata, 32'h12341234);
    cpu_access(1'b0, OP_SW, OP_LW, 32'h10, 32'h0);
    check_val("lw_merge", r_rdata, 32'h1234BEEF);
    check_val("lw_be", {27'h0, r_we, r_be}, 32'hF);

    // Loads from 0x8899AABB at 0x20.
    cpu_access(1'b0, OP_SW, OP_LB, 32'h22, 32'h0);
    check_val("lb_22", r_rdata, exp_lb);
    check_val("lb_stalls", r_stalls, 32'd4);
    cpu_access(1'b0, OP_SW, OP_LHU, 32'h20, 32'h0);
    check_val("lhu_20", r_rdata, 32'h0000AABB);
    cpu_access(1'b0, OP_SW, OP_LH, 32'h22, 32'h0);
    check_val("lh_22", r_rdata, exp_lh);
    cpu_access(1'b0, OP_SW, OP_LBU, 32'h21, 32'h0);
    check_val("lbu_21", r_rdata, 32'h000000AA);

    // Misaligned accesses are dropped with an error pulse.
    cpu_access(1'b0, OP_SW, OP_LW, 32'h06, 32'h0);
    check_val("mis_lw_err", {31'h0, r_err}, 32'h1);
    check_val("mis_lw_stall", r_stalls, 32'd0);
    check_val("mis_lw_rdata", r_rdata, 32'h0);
    check_val("mis_lw_en", r_ens, 32'd0);
    @(negedge clk);
    check_val("mis_lw_no_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk); #1;
    cpu_access(1'b1, OP_SH, OP_LW, 32'h11, 32'h0000FFFF);
    check_val("mis_sh_err", {31'h0, r_err}, 32'h1);
    @(negedge clk);
    check_val("mis_sh_no_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk); #1;

    // Starvation: 4 CPU grants with ext pending, then ext is forced.
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24;
    for (int n = 0; n < 4; n++) begin
      cpu_access(1'b0, OP_SW, OP_LW, 32'h20, 32'h0);
      check_val("starve_cpu_stalls", r_stalls, 32'd4);
      check_val("starve_cpu_rdata", r_rdata, 32'h8899AABB);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_op_l = OP_LW; cpu_addr = 32'h20;
    first_addr = 32'hFFFFFFFF; ext_data = 32'h0; ext_at = -1; cpu_at = -1;
    ext_drop = 1'b0; cdone = 1'b0;
    for (int k = 0; k < 40 && !cdone; k++) begin
      @(negedge clk);
      if (mem_en && first_addr == 32'hFFFFFFFF) first_addr = mem_addr;
      if (ext_done) begin
        ext_at = k; ext_data = ext_rdata; ext_drop = 1'b1;
      end
      if (!cpu_stall) begin
        cdone = 1'b1; cpu_at = k; r_rdata = cpu_rdata;
      end
      @(posedge clk); #1;
      if (ext_drop) ext_req = 1'b0;
      ext_drop = 1'b0;
      if (cdone) cpu_req = 1'b0;
    end
    $display("ext forced: first_addr=%08h ext_done@%0d ext_rdata=%08h cpu_resp@%0d rdata=%08h",
             first_addr, ext_at, ext_data, cpu_at, r_rdata);
    check_val("forced_first_addr", first_addr, 32'h24);
    check_val("forced_ext_done_at", ext_at, 32'd4);
    check_val("forced_ext_rdata", ext_data, 32'h0BADF00D);
    check_val("forced_cpu_resp_at", cpu_at, 32'd9);
    check_val("forced_cpu_rdata", r_rdata, 32'h8899AABB);

    // External full-word write, low address bits ignored; read back by CPU.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h31; ext_wdata = 32'hCAFEF00D;
    ext_at = -1; r_be = 4'h0; r_addr = 32'h0;
    for (int k = 0; k < 30 && ext_at < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin r_be = mem_be; r_addr = mem_addr; end
      if (ext_done) ext_at = k;
      @(posedge clk); #1;
    end
    ext_req = 1'b0; ext_we = 1'b0;
    $display("ext write addr=%08h be=%h done@%0d", r_addr, r_be, ext_at);
    check_val("extw_be", {28'h0, r_be}, 32'hF);
    check_val("extw_addr", r_addr, 32'h30);
    check_val("extw_done_at", ext_at, 32'd4);
    cpu_access(1'b0, OP_SW, OP_LW, 32'h30, 32'h0);
    check_val("extw_readback", r_rdata, 32'hCAFEF00D);

    // Reset during WAIT discards the access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_op_l = OP_LW; cpu_addr = 32'h20;
    @(posedge clk); #1;
    check_val("midrst_en_before", {31'h0, mem_en}, 32'h1);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    check_val("midrst_ctrl", {24'h0, mem_en, mem_we, mem_be, cpu_addr_err, ext_done}, 32'h0);
    check_val("midrst_addr", mem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("midrst_no_resp", {cpu_rdata[30:0], ext_done} | {31'h0, mem_en}, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset pulse applied during WAIT");
    cpu_access(1'b0, OP_SW, OP_LW, 32'h20, 32'h0);
    check_val("postrst_stalls", r_stalls, 32'd4);
    check_val("postrst_rdata", r_rdata, 32'h8899AABB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
